// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Time-shares one purely combinational ALU (ADD/SUB/AND/OR with NZCV flags)
//   between two requesters. Requests are arbitrated round-robin. The accepted
//   operands are registered and drive the ALU for one EXEC cycle. The ALU
//   result and flags are then captured and held on a single response channel,
//   tagged with the requester ID, until the consumer takes them.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready           request handshake per requester
//   req{0,1}_a/_b/_ctrl             operands and ALUControl (00 ADD, 01 SUB, 10 AND, 11 OR)
//   alu_a/alu_b/alu_ctrl            registered operands to the external ALU
//   alu_result/alu_flags            ALU outputs; flags are {N,Z,C,V}
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_result/rsp_flags     captured requester ID, result and flags
//   busy                            high whenever an operation is in flight
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             grant0, grant1, accept;

  logic [WIDTH-1:0] op_a_p0, op_b_p0;
  logic [1:0]       op_ctrl_p0;
  logic             op_id_p0;

  // Grants are only offered in IDLE and never while reset is asserted. On a
  // collision the requester that did not win last time gets the slot, which
  // makes continuous contention alternate 0,1,0,1.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          grant0 = req0_valid & (~req1_valid | last_grant);
          grant1 = req1_valid & (~req0_valid | ~last_grant);
        end
        if (grant0 | grant1) state_next = EXEC;
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_ctrl_p0 <= '0;
      op_id_p0   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_next;

      // Stage p0: capture the granted request into the operand registers
      if (accept) begin
        op_a_p0    <= grant1 ? req1_a    : req0_a;
        op_b_p0    <= grant1 ? req1_b    : req0_b;
        op_ctrl_p0 <= grant1 ? req1_ctrl : req0_ctrl;
        op_id_p0   <= grant1;
        last_grant <= grant1;
      end

      // Stage p1: capture the ALU output at the end of EXEC
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_id     <= op_id_p0;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

  // The ALU always sees the operand registers, whatever the state.
  assign alu_a    = op_a_p0;
  assign alu_b    = op_b_p0;
  assign alu_ctrl = op_ctrl_p0;

endmodule
